div_unit: RTL and testbench

Multi-cycle 32-bit integer divider serving the execute stage alongside the single-cycle ALU. Implements the MIPS DIV/DIVU semantics. Execute issues a `start` pulse and stalls the pipeline while `busy` is high. The unit returns the quotient (LO) and remainder (HI) with a one-cycle `valid` strobe, which the HI/LO write logic consumes.

---
 rtl/div_unit_pkg.sv | 17 +
 rtl/div_unit_step.sv | 29 ++
 rtl/div_unit.sv | 117 +++++++++++
 tb/tb_div_unit.sv | 225 ++++++++++++++++++++++
 4 files changed

// File: rtl/div_unit_pkg.sv
// Shared types and constants for the multi-cycle integer divider.
package div_unit_pkg;

    localparam int DIV_WIDTH = 32;

    typedef enum logic [1:0] {
        DIV_IDLE = 2'd0,
        DIV_CALC = 2'd1,
        DIV_DONE = 2'd2
    } div_state_e;

    // Iteration counter width; guards against a degenerate WIDTH of 1.
    function automatic int div_cnt_width(input int w);
        return (w > 1) ? $clog2(w) : 1;
    endfunction

endpackage

// File: rtl/div_unit_step.sv
// One restoring-division step: shift {rem, quo} left by one and
// trial-subtract the divisor from the upper half.
module div_unit_step
    import div_unit_pkg::*;
#(
    parameter int WIDTH = DIV_WIDTH
) (
    input  logic [WIDTH-1:0] rem,
    input  logic [WIDTH-1:0] quo,
    input  logic [WIDTH-1:0] divisor,
    output logic [WIDTH-1:0] rem_next,
    output logic [WIDTH-1:0] quo_next
);

    logic [WIDTH:0] rem_shift;
    logic [WIDTH:0] trial;
    logic           fits;

    // The shifted remainder can need WIDTH+1 bits, so the trial
    // subtraction is one bit wider; its top bit is the borrow.
    always_comb begin
        rem_shift = {rem, quo[WIDTH-1]};
        trial     = rem_shift - {1'b0, divisor};
        fits      = ~trial[WIDTH];
        rem_next  = fits ? trial[WIDTH-1:0] : rem_shift[WIDTH-1:0];
        quo_next  = {quo[WIDTH-2:0], fits};
    end

endmodule

// File: rtl/div_unit.sv
// Multi-cycle DIV/DIVU unit for the execute stage. Returns {HI, LO} =
// {remainder, quotient} with a one-cycle valid strobe.
//
// state    | meaning
// ---------+-----------------------------------------------------------
// DIV_IDLE | waiting for start; operands sampled here
// DIV_CALC | one restoring step per cycle, WIDTH steps in total
// DIV_DONE | result registered; valid strobe (unless annulled)
module div_unit
    import div_unit_pkg::*;
#(
    parameter int WIDTH = DIV_WIDTH
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic               signed_div,
    input  logic [WIDTH-1:0]   a,
    input  logic [WIDTH-1:0]   b,
    input  logic               annul,
    output logic               busy,
    output logic               valid,
    output logic [2*WIDTH-1:0] result
);

    localparam int CNT_W = div_cnt_width(WIDTH);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

    div_state_e       state;
    logic [CNT_W-1:0] cnt;
    logic [WIDTH-1:0] rem;
    logic [WIDTH-1:0] quo;
    logic [WIDTH-1:0] divisor;
    logic             sign_q;
    logic             sign_r;

    logic [WIDTH-1:0] abs_a;
    logic [WIDTH-1:0] abs_b;
    logic [WIDTH-1:0] rem_next;
    logic [WIDTH-1:0] quo_next;
    logic [WIDTH-1:0] rem_fix;
    logic [WIDTH-1:0] quo_fix;

    div_unit_step #(.WIDTH(WIDTH)) u_step (
        .rem      (rem),
        .quo      (quo),
        .divisor  (divisor),
        .rem_next (rem_next),
        .quo_next (quo_next)
    );

    // Operand magnitudes at load and sign fix-up of the final step.
    // -2^(W-1) maps to itself, which yields the wrapping overflow result.
    always_comb begin
        abs_a   = (signed_div && a[WIDTH-1]) ? (~a + 1'b1) : a;
        abs_b   = (signed_div && b[WIDTH-1]) ? (~b + 1'b1) : b;
        quo_fix = sign_q ? (~quo_next + 1'b1) : quo_next;
        rem_fix = sign_r ? (~rem_next + 1'b1) : rem_next;
    end

    // Moore status; only the valid strobe is gated by a flush.
    assign busy  = (state != DIV_IDLE);
    assign valid = (state == DIV_DONE) && !annul;

    // Control FSM, iteration counter and datapath registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= DIV_IDLE;
            cnt     <= '0;
            rem     <= '0;
            quo     <= '0;
            divisor <= '0;
            sign_q  <= 1'b0;
            sign_r  <= 1'b0;
            result  <= '0;
        end else begin
            case (state)
                DIV_IDLE: begin
                    if (start && !annul) begin
                        rem     <= '0;
                        quo     <= abs_a;
                        divisor <= abs_b;
                        cnt     <= '0;
                        sign_q  <= signed_div & (a[WIDTH-1] ^ b[WIDTH-1]);
                        sign_r  <= signed_div & a[WIDTH-1];
                        if (b == '0) begin
                            result <= {a, {WIDTH{1'b1}}};
                            state  <= DIV_DONE;
                        end else begin
                            state  <= DIV_CALC;
                        end
                    end
                end
                DIV_CALC: begin
                    if (annul) begin
                        state <= DIV_IDLE;
                    end else begin
                        rem <= rem_next;
                        quo <= quo_next;
                        cnt <= cnt + CNT_W'(1);
                        if (cnt == CNT_LAST) begin
                            result <= {rem_fix, quo_fix};
                            state  <= DIV_DONE;
                        end
                    end
                end
                DIV_DONE: begin
                    state <= DIV_IDLE;
                end
                default: begin
                    state <= DIV_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_div_unit.sv
module tb_div_unit;

    logic        clk;
    logic        rst;
    logic        start;
    logic        signed_div;
    logic [31:0] a;
    logic [31:0] b;
    logic        annul;
    logic        busy;
    logic        valid;
    logic [63:0] result;

    int tests;
    int fails;

    div_unit #(.WIDTH(32)) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .signed_div (signed_div),
        .a          (a),
        .b          (b),
        .annul      (annul),
        .busy       (busy),
        .valid      (valid),
        .result     (result)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] va;
        logic [31:0] vb;
        logic        vs;
        logic [63:0] vexp;
        string       vname;
    } vec_t;

    vec_t vecs[10];

    // Reference: plain integer arithmetic on wide signed values.
    function automatic logic [63:0] ref_div(input logic [31:0] x, input logic [31:0] y,
                                            input logic s);
        longint sx;
        longint sy;
        longint q;
        longint r;
        logic [31:0] uq;
        logic [31:0] ur;
        if (y == 32'd0) return {x, 32'hFFFF_FFFF};
        if (s) begin
            sx = longint'($signed(x));
            sy = longint'($signed(y));
            q  = sx / sy;
            r  = sx % sy;
            return {r[31:0], q[31:0]};
        end
        uq = x / y;
        ur = x % y;
        return {ur, uq};
    endfunction

    task automatic check64(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic check_int(input string name, input int act, input int exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Drive one start edge; returns at the negedge right after that edge (E0).
    task automatic issue(input logic [31:0] ta, input logic [31:0] tb_, input logic ts);
        @(negedge clk);
        start      = 1'b1;
        a          = ta;
        b          = tb_;
        signed_div = ts;
        @(negedge clk);
        start      = 1'b0;
        a          = $urandom;
        b          = $urandom;
        signed_div = 1'($urandom_range(0, 1));
    endtask

    task automatic do_div(input logic [31:0] ta, input logic [31:0] tb_, input logic ts,
                          input logic [63:0] exp_res, input string name);
        bit          seen;
        bit          busy_ok;
        int          edge_n;
        logic [63:0] got;
        seen    = 1'b0;
        busy_ok = 1'b1;
        edge_n  = -1;
        got     = 'x;
        issue(ta, tb_, ts);
        for (int i = 0; i < 40 && !seen; i++) begin
            if (i > 0) @(negedge clk);
            if (!busy) busy_ok = 1'b0;
            if (valid) begin
                seen   = 1'b1;
                edge_n = i;
                got    = result;
            end
        end
        check_int({name, " latency"}, edge_n, (tb_ == 32'd0) ? 0 : 32);
        check64({name, " result"}, got, exp_res);
        @(negedge clk);
        check_int({name, " busy/valid"}, {busy_ok, busy, valid}, 3'b100);
    endtask

    initial begin
        logic [63:0] prior;
        logic [31:0] ra;
        logic [31:0] rb;
        logic        rs;
        int          vcnt;
        int          sel;

        tests = 0;
        fails = 0;
        rst = 1'b1; start = 1'b0; signed_div = 1'b0; a = '0; b = '0; annul = 1'b0;

        vecs[0] = '{32'd100,       32'd7,         1'b0, {32'd2,        32'd14},       "divu_100_7"};
        vecs[1] = '{32'hFFFF_FFF9, 32'd2,         1'b1, {32'hFFFF_FFFF, 32'hFFFF_FFFD}, "div_m7_2"};
        vecs[2] = '{32'hFFFF_FFF9, 32'd2,         1'b0, {32'd1,        32'h7FFF_FFFC}, "divu_m7_2"};
        vecs[3] = '{32'h8000_0000, 32'hFFFF_FFFF, 1'b1, {32'd0,        32'h8000_0000}, "div_ovf"};
        vecs[4] = '{32'h1234_5678, 32'd0,         1'b0, {32'h1234_5678, 32'hFFFF_FFFF}, "divu_by0"};
        vecs[5] = '{32'hFFFF_FFF8, 32'd0,         1'b1, {32'hFFFF_FFF8, 32'hFFFF_FFFF}, "div_by0"};
        vecs[6] = '{32'd7,         32'hFFFF_FFFE, 1'b1, {32'd1,        32'hFFFF_FFFD}, "div_7_m2"};
        vecs[7] = '{32'hFFFF_FFF8, 32'hFFFF_FFFD, 1'b1, {32'hFFFF_FFFE, 32'd2},        "div_m8_m3"};
        vecs[8] = '{32'hFFFF_FFFF, 32'd1,         1'b0, {32'd0,        32'hFFFF_FFFF}, "divu_max_1"};
        vecs[9] = '{32'd5,         32'd10,        1'b0, {32'd5,        32'd0},         "divu_5_10"};

        repeat (3) @(negedge clk);
        check_int("reset busy/valid", {busy, valid}, 0);
        check64("reset result", result, 64'd0);
        rst = 1'b0;

        for (int i = 0; i < 10; i++)
            do_div(vecs[i].va, vecs[i].vb, vecs[i].vs, vecs[i].vexp, vecs[i].vname);

        // start during an active operation is ignored
        issue(32'd100, 32'd7, 1'b0);
        vcnt = 0;
        for (int i = 0; i < 45; i++) begin
            if (i > 0) @(negedge clk);
            if (i == 10) begin start = 1'b1; a = 32'd5; b = 32'd1; end
            if (i == 11) start = 1'b0;
            if (valid) vcnt++;
        end
        check_int("ignored start valid count", vcnt, 1);
        check64("ignored start result", result, {32'd2, 32'd14});
        prior = {32'd2, 32'd14};

        // annul mid-CALC
        issue(32'd1000, 32'd3, 1'b0);
        repeat (14) @(negedge clk);
        annul = 1'b1;
        @(negedge clk);
        annul = 1'b0;
        check_int("annul busy drop", busy, 0);
        vcnt = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (valid || busy) vcnt++;
        end
        check_int("annul no valid", vcnt, 0);
        check64("annul keeps result", result, prior);
        do_div(32'd1000, 32'd3, 1'b0, {32'd1, 32'd333}, "after_annul");

        // annul in IDLE beats start
        @(negedge clk);
        start = 1'b1; annul = 1'b1; a = 32'd9; b = 32'd2; signed_div = 1'b0;
        @(negedge clk);
        start = 1'b0; annul = 1'b0;
        check_int("idle annul priority", {busy, valid}, 0);

        // annul during DONE gates valid
        issue(32'd77, 32'd0, 1'b0);
        annul = 1'b1;
        #1;
        check_int("done annul gates valid", valid, 0);
        @(negedge clk);
        annul = 1'b0;
        check_int("done annul idle", {busy, valid}, 0);

        // asynchronous reset mid-CALC
        issue(32'd500, 32'd9, 1'b0);
        repeat (12) @(negedge clk);
        #2 rst = 1'b1;
        #1;
        check_int("async rst busy/valid", {busy, valid}, 0);
        check64("async rst result", result, 64'd0);
        @(negedge clk);
        rst = 1'b0;
        do_div(32'd500, 32'd9, 1'b0, {32'd5, 32'd55}, "after_rst");

        // randomized against the reference model
        for (int i = 0; i < 40; i++) begin
            ra  = $urandom;
            rb  = $urandom;
            rs  = 1'($urandom_range(0, 1));
            sel = $urandom_range(0, 9);
            if (sel == 0) rb = 32'd0;
            if (sel == 1) rb = 32'hFFFF_FFFF;
            if (sel == 2) ra = 32'h8000_0000;
            if (sel == 3) rb = 32'($urandom_range(1, 300));
            do_div(ra, rb, rs, ref_div(ra, rb, rs), $sformatf("rand%0d", i));
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
